// File: rtl/spi_flash_dma_pkg.sv
// Shared definitions for the SPI flash to memory DMA: spi register map,
// transfer width codes and control-register field positions.
package spi_flash_dma_pkg;

  localparam int unsigned SPI_AW = 2;

  localparam logic [SPI_AW-1:0] DATAREG = 2'd0;
  localparam logic [SPI_AW-1:0] IMMDATA = 2'd1;
  localparam logic [SPI_AW-1:0] CTRLREG = 2'd2;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    TRIPLE = 2'd2,
    WORD   = 2'd3
  } xfer_width_e;

  localparam int unsigned CTRL_SS_LSB        = 8;
  localparam int unsigned CTRL_SS_MSB        = 9;
  localparam int unsigned CTRL_ENDIAN_BIT    = 16;
  localparam int unsigned CTRL_SS_ACTIVE_BIT = 24;

  // Assemble a spi control-register value from its fields.
  function automatic logic [31:0] ctrl_word(input logic [1:0]  ss,
                                            input logic        big_endian,
                                            input logic        ss_active,
                                            input xfer_width_e width);
    logic [31:0] w;
    w = '0;
    w[1:0] = width;
    w[CTRL_SS_MSB:CTRL_SS_LSB] = ss;
    w[CTRL_ENDIAN_BIT] = big_endian;
    w[CTRL_SS_ACTIVE_BIT] = ss_active;
    return w;
  endfunction

endpackage

// File: rtl/spi_flash_dma.sv
// Copies word_count 32-bit words from SPI flash into memory: configures the
// spi block, issues a read command, then streams captured words to memory.
module spi_flash_dma
  import spi_flash_dma_pkg::*;
#(
  parameter logic [1:0] FLASH_SS = 2'd0,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] flash_addr,
  input  logic [31:0] mem_base,
  input  logic [15:0] word_count,
  input  logic        swap,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        spi_select,
  output logic        spi_rd,
  output logic [3:0]  spi_we,
  output logic [1:0]  spi_addr,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  input  logic        spi_wbusy,
  input  logic        spi_rbusy,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {IDLE, CFG, CMD, RD, MEMWR, RELEASE, FIN} state_e;

  state_e      state, state_n;
  logic [23:0] faddr_q, faddr_n;
  logic [15:0] remain_q, remain_n;
  logic        swap_q, swap_n;
  logic        discard_q, discard_n;
  logic        abort_q, abort_n;
  logic [31:0] maddr_n, mwdata_n;
  logic        busy_n, done_n, sel_n, rd_n, mem_we_n;
  logic [3:0]  we_n;
  logic [1:0]  saddr_n;
  logic [31:0] swdata_n;

  // Next state and next register values; outputs are decoded from the next
  // state so that each registered output is valid for the whole state.
  always_comb begin
    state_n   = state;
    faddr_n   = faddr_q;
    remain_n  = remain_q;
    swap_n    = swap_q;
    discard_n = discard_q;
    abort_n   = abort_q | (abort & (state != IDLE));
    maddr_n   = mem_addr;
    mwdata_n  = mem_wdata;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          faddr_n   = flash_addr;
          maddr_n   = mem_base;
          remain_n  = word_count;
          swap_n    = swap;
          discard_n = 1'b1;
          abort_n   = 1'b0;
          busy_n    = 1'b1;
          state_n   = (word_count == 16'd0) ? FIN : CFG;
        end
      end
      CFG:     state_n = CMD;
      CMD:     if (!spi_wbusy) state_n = RD;
      RD: begin
        // The first capture is the echo of the command transfer.
        if (!spi_rbusy) begin
          if (discard_q) begin
            discard_n = 1'b0;
            state_n   = abort_n ? RELEASE : RD;
          end else begin
            mwdata_n = spi_rdata;
            state_n  = abort_n ? RELEASE : MEMWR;
          end
        end
      end
      MEMWR: begin
        if (mem_ready) begin
          maddr_n  = mem_addr + 32'd1;
          remain_n = remain_q - 16'd1;
          state_n  = (remain_q == 16'd1 || abort_n) ? RELEASE : RD;
        end
      end
      RELEASE: state_n = FIN;
      FIN: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    sel_n    = 1'b0;
    rd_n     = 1'b0;
    we_n     = 4'b0000;
    saddr_n  = '0;
    swdata_n = '0;
    mem_we_n = 1'b0;
    case (state_n)
      CFG: begin
        sel_n    = 1'b1;
        saddr_n  = CTRLREG;
        we_n     = 4'b1111;
        swdata_n = ctrl_word(FLASH_SS, ~swap_n, 1'b1, WORD);
      end
      CMD: begin
        sel_n    = 1'b1;
        saddr_n  = DATAREG;
        we_n     = 4'b1111;
        swdata_n = {CMD_READ, faddr_n};
      end
      RD: begin
        sel_n   = 1'b1;
        rd_n    = 1'b1;
        saddr_n = DATAREG;
      end
      MEMWR: mem_we_n = 1'b1;
      RELEASE: begin
        sel_n    = 1'b1;
        saddr_n  = CTRLREG;
        we_n     = 4'b1000;
        swdata_n = ctrl_word(FLASH_SS, ~swap_n, 1'b0, WORD);
      end
      default: ;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      faddr_q    <= '0;
      remain_q   <= '0;
      swap_q     <= 1'b0;
      discard_q  <= 1'b0;
      abort_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_select <= 1'b0;
      spi_rd     <= 1'b0;
      spi_we     <= '0;
      spi_addr   <= '0;
      spi_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      faddr_q    <= faddr_n;
      remain_q   <= remain_n;
      swap_q     <= swap_n;
      discard_q  <= discard_n;
      abort_q    <= abort_n;
      busy       <= busy_n;
      done       <= done_n;
      spi_select <= sel_n;
      spi_rd     <= rd_n;
      spi_we     <= we_n;
      spi_addr   <= saddr_n;
      spi_wdata  <= swdata_n;
      mem_we     <= mem_we_n;
      mem_addr   <= maddr_n;
      mem_wdata  <= mwdata_n;
    end
  end

endmodule

// File: tb/tb_spi_flash_dma.sv
// Bench for spi_flash_dma: byte-addressed flash behind a simple spi model,
// randomized handshakes, and a word-level expectation of memory writes.
module tb_spi_flash_dma;
  import spi_flash_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, swap, abort;
  logic [23:0] flash_addr;
  logic [31:0] mem_base;
  logic [15:0] word_count;
  logic        busy, done, spi_select, spi_rd;
  logic [3:0]  spi_we;
  logic [1:0]  spi_addr;
  logic [31:0] spi_wdata, spi_rdata;
  logic        spi_wbusy, spi_rbusy;
  logic        mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata;

  int total = 0;
  int bad = 0;

  spi_flash_dma dut (
    .clk(clk), .reset(reset), .start(start), .flash_addr(flash_addr),
    .mem_base(mem_base), .word_count(word_count), .swap(swap), .abort(abort),
    .busy(busy), .done(done), .spi_select(spi_select), .spi_rd(spi_rd),
    .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_wbusy(spi_wbusy), .spi_rbusy(spi_rbusy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash contents: explicit bytes where a test places them, a hash elsewhere.
  logic [7:0] flash_mem [int];

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (flash_mem.exists(int'(a))) return flash_mem[int'(a)];
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
  endfunction

  // Expected memory image: word k holds flash bytes fa+4k..fa+4k+3.
  logic [31:0] exp_addr[$], exp_data[$];
  function automatic void build_expected(input logic [23:0] fa, input logic [31:0] mb,
                                         input int n, input logic sw);
    exp_addr.delete();
    exp_data.delete();
    for (int k = 0; k < n; k++) begin
      logic [7:0] b [4];
      for (int j = 0; j < 4; j++) b[j] = fbyte(fa + 24'(4 * k + j));
      exp_addr.push_back(mb + 32'(k));
      exp_data.push_back(sw ? {b[3], b[2], b[1], b[0]} : {b[0], b[1], b[2], b[3]});
    end
  endfunction

  // SPI device: reads return one transfer late, the first being the command echo.
  logic [31:0] ctrl_q;
  logic [23:0] cmd_addr;
  int          rd_idx;
  always @(posedge clk) begin : spi_model
    int nidx;
    logic [23:0] na;
    logic big;
    logic [7:0] b0, b1, b2, b3;
    nidx = rd_idx;
    na = cmd_addr;
    big = ctrl_q[16];
    if (reset) begin
      ctrl_q <= '0;
      cmd_addr <= '0;
      rd_idx <= 0;
      spi_rdata <= '0;
    end else begin
      if (spi_select && spi_addr == CTRLREG && spi_we == 4'hF) begin
        ctrl_q <= spi_wdata;
        big = spi_wdata[16];
      end
      if (spi_select && spi_addr == DATAREG && spi_we == 4'hF && !spi_wbusy) begin
        na = spi_wdata[23:0];
        nidx = 0;
      end else if (spi_select && spi_rd && !spi_rbusy) begin
        nidx = rd_idx + 1;
      end
      cmd_addr <= na;
      rd_idx <= nidx;
      b0 = fbyte(na + 24'(4 * (nidx - 1)));
      b1 = fbyte(na + 24'(4 * (nidx - 1) + 1));
      b2 = fbyte(na + 24'(4 * (nidx - 1) + 2));
      b3 = fbyte(na + 24'(4 * (nidx - 1) + 3));
      if (nidx == 0) spi_rdata <= {8'h03, na};
      else spi_rdata <= big ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    end
  end

  // Random handshake responses, with an optional forced memory stall.
  int mem_stall_req = 0;
  always @(posedge clk) begin
    #1;
    spi_wbusy = ($urandom_range(0, 2) == 0);
    spi_rbusy = ($urandom_range(0, 2) == 0);
    if (mem_we && mem_stall_req > 0) begin
      mem_ready = 1'b0;
      mem_stall_req = mem_stall_req - 1;
    end else begin
      mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Observation logs, sampled on the falling edge.
  logic [31:0] wq_addr[$], wq_data[$], sq_data[$];
  logic [1:0]  sq_addr[$];
  logic [3:0]  sq_we[$];
  int sel_cnt, mem_we_cnt, done_cnt, done_cyc, start_cyc, proto_err, stall_err;
  int stall_run, max_stall;
  logic prev_stall;
  logic [31:0] prev_maddr, prev_mdata;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we && mem_ready) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
      end
      if (spi_we != 4'd0 && (spi_addr != DATAREG || !spi_wbusy)) begin
        sq_addr.push_back(spi_addr);
        sq_we.push_back(spi_we);
        sq_data.push_back(spi_wdata);
      end
      if (spi_select) sel_cnt++;
      if (mem_we) mem_we_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (start && !busy) start_cyc = cyc;
      if (spi_rd && spi_we != 4'd0) proto_err++;
      if (mem_we && (spi_select || spi_rd || spi_we != 4'd0)) proto_err++;
      if (!busy && (spi_select || spi_rd || spi_we != 4'd0 || mem_we)) proto_err++;
      if (mem_we && prev_stall && (mem_addr !== prev_maddr || mem_wdata !== prev_mdata))
        stall_err++;
      if (mem_we && !mem_ready) begin
        stall_run++;
        if (stall_run > max_stall) max_stall = stall_run;
      end else stall_run = 0;
      prev_stall = mem_we && !mem_ready;
      prev_maddr = mem_addr;
      prev_mdata = mem_wdata;
    end
  end

  task automatic clear_logs();
    wq_addr.delete(); wq_data.delete();
    sq_addr.delete(); sq_we.delete(); sq_data.delete();
    sel_cnt = 0; mem_we_cnt = 0; done_cnt = 0; done_cyc = -1; start_cyc = -1;
    proto_err = 0; stall_err = 0; stall_run = 0; max_stall = 0; prev_stall = 1'b0;
  endtask

  task automatic do_xfer(input logic [23:0] fa, input logic [31:0] mb, input logic [15:0] wc,
                         input logic sw, output bit timed_out);
    clear_logs();
    @(posedge clk); #1;
    flash_addr = fa; mem_base = mb; word_count = wc; swap = sw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin timed_out = 1'b0; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; swap = 1'b0;
    flash_addr = '0; mem_base = '0; word_count = '0;
    spi_wbusy = 1'b0; spi_rbusy = 1'b0; mem_ready = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, spi_select, spi_rd, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, spi_select, spi_rd, mem_we});
    end
    total++;
    if ({spi_we, spi_addr, spi_wdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_bus got we=%h a=%h wd=%h ma=%h md=%h exp=all zero",
                      spi_we, spi_addr, spi_wdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    bit to;
    flash_mem[32'h1000] = 8'hDE; flash_mem[32'h1001] = 8'hAD;
    flash_mem[32'h1002] = 8'hBE; flash_mem[32'h1003] = 8'hEF;
    flash_mem[32'h1004] = 8'h01; flash_mem[32'h1005] = 8'h23;
    flash_mem[32'h1006] = 8'h45; flash_mem[32'h1007] = 8'h67;
    do_xfer(24'h001000, 32'h100, 16'd2, 1'b0, to);
    total++;
    if (to) begin bad++; $display("FAIL dir_timeout got=no done exp=done"); end
    total++;
    if (sq_addr.size() != 3) begin
      bad++; $display("FAIL dir_spi_writes got=%0d exp=3", sq_addr.size());
    end else begin
      total++;
      if (sq_addr[0] !== CTRLREG || sq_we[0] !== 4'hF || sq_data[0] !== 32'h0101_0003) begin
        bad++; $display("FAIL dir_cfg got a=%0d we=%h d=%h exp a=2 we=f d=01010003",
                        sq_addr[0], sq_we[0], sq_data[0]);
      end
      total++;
      if (sq_addr[1] !== DATAREG || sq_we[1] !== 4'hF || sq_data[1] !== 32'h0300_1000) begin
        bad++; $display("FAIL dir_cmd got a=%0d we=%h d=%h exp a=0 we=f d=03001000",
                        sq_addr[1], sq_we[1], sq_data[1]);
      end
      total++;
      if (sq_addr[2] !== CTRLREG || sq_we[2] !== 4'h8 || sq_data[2][24] !== 1'b0) begin
        bad++; $display("FAIL dir_release got a=%0d we=%h d=%h exp a=2 we=8 bit24=0",
                        sq_addr[2], sq_we[2], sq_data[2]);
      end
    end
    total++;
    if (wq_addr.size() != 2) begin
      bad++; $display("FAIL dir_nwrites got=%0d exp=2", wq_addr.size());
    end else begin
      total++;
      if (wq_addr[0] !== 32'h100 || wq_data[0] !== 32'hDEADBEEF) begin
        bad++; $display("FAIL dir_word0 got %h=%h exp 00000100=deadbeef", wq_addr[0], wq_data[0]);
      end
      total++;
      if (wq_addr[1] !== 32'h101 || wq_data[1] !== 32'h01234567) begin
        bad++; $display("FAIL dir_word1 got %h=%h exp 00000101=01234567", wq_addr[1], wq_data[1]);
      end
    end
    total++;
    if (done_cnt != 1 || proto_err != 0) begin
      bad++; $display("FAIL dir_done got done=%0d proto=%0d exp 1/0", done_cnt, proto_err);
    end
  endtask

  task automatic test_zero_count();
    bit to;
    do_xfer(24'($urandom), $urandom, 16'd0, 1'b0, to);
    total++;
    if (to || done_cyc - start_cyc != 2) begin
      bad++; $display("FAIL zero_latency got=%0d exp=2", done_cyc - start_cyc);
    end
    total++;
    if (sel_cnt != 0 || mem_we_cnt != 0 || done_cnt != 1) begin
      bad++; $display("FAIL zero_activity got sel=%0d we=%0d done=%0d exp 0/0/1",
                      sel_cnt, mem_we_cnt, done_cnt);
    end
  endtask

  task automatic test_mem_stall();
    bit to;
    logic [23:0] fa;
    logic [31:0] mb;
    logic sw;
    fa = 24'($urandom); mb = $urandom; sw = 1'($urandom);
    mem_stall_req = 5;
    do_xfer(fa, mb, 16'd3, sw, to);
    build_expected(fa, mb, 3, sw);
    total++;
    if (to || max_stall < 5) begin
      bad++; $display("FAIL stall_len got=%0d exp>=5", max_stall);
    end
    total++;
    if (stall_err != 0 || proto_err != 0) begin
      bad++; $display("FAIL stall_stable got err=%0d proto=%0d exp 0/0", stall_err, proto_err);
    end
    total++;
    if (wq_addr.size() != exp_addr.size()) begin
      bad++; $display("FAIL stall_nwrites got=%0d exp=%0d", wq_addr.size(), exp_addr.size());
    end
    foreach (exp_addr[i]) if (i < wq_addr.size()) begin
      total++;
      if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
        bad++; $display("FAIL stall_word%0d got %h=%h exp %h=%h", i,
                        wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_abort();
    bit to;
    logic [23:0] fa;
    logic [31:0] mb;
    fa = 24'($urandom); mb = $urandom;
    fork
      do_xfer(fa, mb, 16'd4, 1'b0, to);
      begin
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk); #2;
          if (mem_we && wq_addr.size() == 1) begin
            abort = 1'b1;
            @(posedge clk); #2;
            abort = 1'b0;
            break;
          end
          if (i > 5 && !busy) break;
        end
      end
    join
    build_expected(fa, mb, 2, 1'b0);
    total++;
    if (to || done_cnt != 1) begin
      bad++; $display("FAIL abort_done got timeout=%0d done=%0d exp 0/1", to, done_cnt);
    end
    total++;
    if (wq_addr.size() != 2) begin
      bad++; $display("FAIL abort_nwrites got=%0d exp=2", wq_addr.size());
    end else begin
      total++;
      if (wq_addr[1] !== exp_addr[1] || wq_data[1] !== exp_data[1]) begin
        bad++; $display("FAIL abort_word1 got %h=%h exp %h=%h",
                        wq_addr[1], wq_data[1], exp_addr[1], exp_data[1]);
      end
    end
    total++;
    if (sq_addr.size() == 0 || sq_we[sq_we.size()-1] !== 4'h8 ||
        sq_addr[sq_addr.size()-1] !== CTRLREG) begin
      bad++; $display("FAIL abort_release got n=%0d exp last access a=2 we=8", sq_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    bit to, seen;
    clear_logs();
    @(posedge clk); #1;
    flash_addr = 24'h00_4000; mem_base = 32'h40; word_count = 16'd3; swap = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (spi_rd) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL rmid_reach_rd got=no spi_rd exp=spi_rd"); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, spi_select, spi_rd, mem_we, spi_we, spi_addr, spi_wdata, mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL rmid_outputs got busy=%b sel=%b rd=%b we=%h ma=%h exp all zero",
                      busy, spi_select, spi_rd, spi_we, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    total++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_no_done got done=%0d busy=%b exp 0/0", done_cnt, busy);
    end
    do_xfer(24'h00_4000, 32'h40, 16'd3, 1'b0, to);
    build_expected(24'h00_4000, 32'h40, 3, 1'b0);
    total++;
    if (to || wq_addr.size() != 3 || wq_data[2] !== exp_data[2] || wq_addr[2] !== exp_addr[2]) begin
      bad++; $display("FAIL rmid_rerun got n=%0d exp 3 correct writes", wq_addr.size());
    end
  endtask

  task automatic test_swap();
    bit to;
    flash_mem[32'h2000] = 8'h11; flash_mem[32'h2001] = 8'h22;
    flash_mem[32'h2002] = 8'h33; flash_mem[32'h2003] = 8'h44;
    do_xfer(24'h002000, 32'h200, 16'd1, 1'b1, to);
    total++;
    if (to || wq_data.size() != 1) begin
      bad++; $display("FAIL swap_nwrites got=%0d exp=1", wq_data.size());
    end else begin
      total++;
      if (wq_data[0] !== 32'h44332211) begin
        bad++; $display("FAIL swap_data got=%h exp=44332211", wq_data[0]);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic [23:0] fa;
    logic [31:0] mb;
    logic [15:0] wc;
    logic sw;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      fa = 24'($urandom);
      mb = (t == 2) ? 32'hFFFF_FFFE : $urandom;
      wc = 16'($urandom_range(1, 6));
      sw = 1'($urandom);
      do_xfer(fa, mb, wc, sw, to);
      build_expected(fa, mb, int'(wc), sw);
      total++;
      if (to || wq_addr.size() != exp_addr.size() || proto_err != 0) begin
        bad++; $display("FAIL rand%0d_count got=%0d proto=%0d exp=%0d/0", t,
                        wq_addr.size(), proto_err, exp_addr.size());
      end
      foreach (exp_addr[i]) if (i < wq_addr.size()) begin
        total++;
        if (wq_addr[i] !== exp_addr[i] || wq_data[i] !== exp_data[i]) begin
          bad++; $display("FAIL rand%0d_word%0d got %h=%h exp %h=%h", t, i,
                          wq_addr[i], wq_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    fork
      do_xfer(24'h00_8000, 32'h800, 16'd4, 1'b0, to);
      begin
        repeat (8) @(posedge clk);
        #1;
        flash_addr = 24'hABCDEF; mem_base = 32'h9999; word_count = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    build_expected(24'h00_8000, 32'h800, 4, 1'b0);
    total++;
    if (to || done_cnt != 1 || wq_addr.size() != 4) begin
      bad++; $display("FAIL b2b_ignored_start got done=%0d n=%0d exp 1/4", done_cnt, wq_addr.size());
    end else begin
      total++;
      if (wq_addr[3] !== exp_addr[3] || wq_data[3] !== exp_data[3]) begin
        bad++; $display("FAIL b2b_word3 got %h=%h exp %h=%h",
                        wq_addr[3], wq_data[3], exp_addr[3], exp_data[3]);
      end
    end
    do_xfer(24'h00_9000, 32'h900, 16'd2, 1'b1, to);
    build_expected(24'h00_9000, 32'h900, 2, 1'b1);
    total++;
    if (to || wq_addr.size() != 2 || wq_data[1] !== exp_data[1] || wq_addr[1] !== exp_addr[1]) begin
      bad++; $display("FAIL b2b_second got n=%0d exp 2 correct writes", wq_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_count();
    test_mem_stall();
    test_abort();
    test_reset_mid();
    test_swap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
